// File: rtl/mld_7_encoder_pkg.sv
// Shared definitions for the 7-bit cyclic majority-logic code (N=7, K=3).
// The encoder and every consumer of its check sums use these definitions.
package mld_pkg;

    localparam int MLD_N = 7;
    localparam int MLD_K = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        HOLD = 2'd2
    } mld_state_e;

    // Check-sum index sets {3,4,6}, {1,5,6}, {0,2,6} as bit masks over c[0:6]; all orthogonal on c[6].
    localparam logic [0:MLD_N-1] MLD_CHK_MASK [0:2] = '{7'b0001101, 7'b0100011, 7'b1010001};

    function automatic logic [0:2] mld_check_sums(input logic [0:MLD_N-1] c);
        logic [0:2] s;
        s = 3'b000;
        for (int j = 0; j < 3; j++) begin
            s[j] = ^(c & MLD_CHK_MASK[j]);
        end
        return s;
    endfunction

endpackage

// File: rtl/mld_7_encoder.sv
// Serial systematic encoder: parity c[3..6] generated one bit per cycle by the
// recurrence c[k] = c[k-3] ^ c[k-2], then presented (optionally corrupted) until consumed.
module mld_7_encoder
    import mld_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                msg_valid,
    input  logic [0:MLD_K-1]    message,
    input  logic [0:MLD_N-1]    err_mask,
    output logic                msg_ready,
    output logic [0:MLD_N-1]    codeword,
    output logic                codeword_valid,
    input  logic                codeword_ready
);

    mld_state_e         r_state;
    mld_state_e         w_state_next;
    logic [0:MLD_N-1]   r_sr;
    logic [0:MLD_N-1]   w_sr_next;
    logic [0:MLD_N-1]   r_mask;
    logic [0:MLD_N-1]   w_mask_next;
    logic [0:MLD_N-1]   r_codeword;
    logic [2:0]         r_k;
    logic [2:0]         w_k_next;
    logic               r_msg_ready;
    logic               r_cw_valid;
    logic               w_load_cw;

    // Next-state, recurrence step and counter update.
    always_comb begin
        w_state_next = r_state;
        w_sr_next    = r_sr;
        w_mask_next  = r_mask;
        w_k_next     = r_k;
        w_load_cw    = 1'b0;
        case (r_state)
            IDLE: begin
                // Accept only once msg_ready is visible, so the first edge after reset never accepts.
                if (msg_valid && r_msg_ready) begin
                    w_sr_next    = {message, 4'b0000};
                    w_mask_next  = err_mask;
                    w_k_next     = 3'd3;
                    w_state_next = GEN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            GEN: begin
                w_sr_next[r_k] = r_sr[r_k - 3'd3] ^ r_sr[r_k - 3'd2];
                w_k_next       = r_k + 3'd1;
                if (r_k == 3'd6) begin
                    w_state_next = HOLD;
                    w_load_cw    = 1'b1;
                end else begin
                    w_state_next = GEN;
                end
            end
            HOLD: begin
                if (codeword_ready) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = HOLD;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_sr        <= 7'b0000000;
            r_mask      <= 7'b0000000;
            r_k         <= 3'd0;
            r_codeword  <= 7'b0000000;
            r_msg_ready <= 1'b0;
            r_cw_valid  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_sr        <= w_sr_next;
            r_mask      <= w_mask_next;
            r_k         <= w_k_next;
            r_msg_ready <= (w_state_next == IDLE);
            r_cw_valid  <= (w_state_next == HOLD);
            // The presented word is frozen on HOLD entry and kept after consume.
            if (w_load_cw) begin
                r_codeword <= w_sr_next ^ r_mask;
            end else begin
                r_codeword <= r_codeword;
            end
        end
    end

    assign msg_ready      = r_msg_ready;
    assign codeword       = r_codeword;
    assign codeword_valid = r_cw_valid;

endmodule

// File: tb/tb_mld_7_encoder.sv
// Directed bench for mld_7_encoder with closed-form expectations and a
// majority-logic decoder model as golden checker.
module tb_mld_7_encoder;
    import mld_pkg::*;

    logic           clk;
    logic           reset;
    logic           msg_valid;
    logic [0:2]     message;
    logic [0:6]     err_mask;
    logic           msg_ready;
    logic [0:6]     codeword;
    logic           codeword_valid;
    logic           codeword_ready;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mld_7_encoder dut (
        .clk            (clk),
        .reset          (reset),
        .msg_valid      (msg_valid),
        .message        (message),
        .err_mask       (err_mask),
        .msg_ready      (msg_ready),
        .codeword       (codeword),
        .codeword_valid (codeword_valid),
        .codeword_ready (codeword_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:6] enc(input logic [0:2] m);
        return {m[0], m[1], m[2], m[0] ^ m[1], m[1] ^ m[2], m[0] ^ m[1] ^ m[2], m[0] ^ m[2]};
    endfunction

    function automatic logic [0:6] mld_decode(input logic [0:6] r);
        logic [0:6] w;
        logic [0:2] s;
        w = r;
        for (int t = 0; t < 7; t++) begin
            s = mld_check_sums(w);
            if ((s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2])) w[6] = ~w[6];
            w = {w[6], w[0:5]};
        end
        return w;
    endfunction

    task automatic send(input logic [0:2] m, input logic [0:6] mask,
                        output logic [0:6] cw, output int acc);
        int n;
        n = 0;
        while (msg_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("msg_ready_wait", msg_ready, 1);
        msg_valid = 1'b1;
        message   = m;
        err_mask  = mask;
        @(posedge clk); #1;
        acc       = cyc;
        msg_valid = 1'b0;
        message   = ~m;
        err_mask  = ~mask;
        n = 0;
        while (codeword_valid !== 1'b1 && n < 20) begin
            chk("ready_low_gen", msg_ready, 0);
            @(posedge clk); #1; n++;
        end
        chk("latency", n, 4);
        chk("ready_low_hold", msg_ready, 0);
        cw = codeword;
    endtask

    task automatic consume();
        codeword_ready = 1'b1;
        @(posedge clk); #1;
        chk("valid_drop", codeword_valid, 0);
        chk("ready_back", msg_ready, 1);
    endtask

    initial begin
        logic [0:6] cw, cw2, rot, exp_cw, mk;
        logic [0:6] set [8];
        int acc1, acc2, found;

        reset = 1'b0; msg_valid = 1'b0; message = 3'b000;
        err_mask = 7'b0000000; codeword_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_codeword", codeword, 7'b0000000);
        chk("rst_valid", codeword_valid, 0);
        chk("rst_ready", msg_ready, 0);
        @(negedge clk); reset = 1'b1;
        #1 chk("ready_before_edge", msg_ready, 0);
        @(posedge clk); #1;
        chk("ready_after_release", msg_ready, 1);

        // Basic encode of 100
        codeword_ready = 1'b1;
        send(3'b100, 7'b0000000, cw, acc1);
        chk("cw_100", cw, 7'b1001011);
        chk("chk_sums_100", mld_check_sums(cw), 3'b000);
        consume();

        // Back-to-back with ready held high
        send(3'b111, 7'b0000000, cw, acc1);
        chk("cw_111", cw, 7'b1110010);
        consume();
        send(3'b010, 7'b0000000, cw2, acc2);
        chk("cw_010", cw2, 7'b0101110);
        chk("accept_spacing", acc2 - acc1, 6);
        consume();

        // Exhaustive against closed forms, then cyclic closure
        for (int m = 0; m < 8; m++) begin
            send(3'(m), 7'b0000000, cw, acc1);
            chk("closed_form", cw, enc(3'(m)));
            chk("chk_sums", mld_check_sums(cw), 3'b000);
            set[m] = cw;
            consume();
        end
        for (int i = 0; i < 8; i++) begin
            rot = set[i];
            for (int r = 1; r < 7; r++) begin
                rot = {rot[6], rot[0:5]};
                found = 0;
                for (int j = 0; j < 8; j++) if (set[j] === rot) found = 1;
                chk("rotation_member", found, 1);
            end
        end

        // Back-pressure with masked bit and ignored msg_valid pulses
        codeword_ready = 1'b0;
        send(3'b100, 7'b0000001, cw, acc1);
        for (int i = 0; i < 10; i++) begin
            chk("hold_cw", codeword, 7'b1001010);
            chk("hold_valid", codeword_valid, 1);
            chk("hold_ready_low", msg_ready, 0);
            msg_valid = (i % 2 == 0);
            message   = 3'b011;
            @(posedge clk); #1;
        end
        msg_valid = 1'b0;
        consume();
        chk("cw_kept_after_consume", codeword, 7'b1001010);
        @(posedge clk); #1;
        chk("no_queued_accept", msg_ready, 1);
        chk("no_queued_valid", codeword_valid, 0);

        // Reset during the second GEN cycle
        codeword_ready = 1'b1;
        msg_valid = 1'b1; message = 3'b111; err_mask = 7'b0000000;
        @(posedge clk); #1;
        msg_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("midrst_codeword", codeword, 7'b0000000);
        chk("midrst_valid", codeword_valid, 0);
        chk("midrst_ready", msg_ready, 0);
        @(negedge clk); reset = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("discarded_partial", codeword_valid, 0);
        end
        send(3'b010, 7'b0000000, cw, acc1);
        chk("cw_010_after_rst", cw, 7'b0101110);
        consume();

        // Encoder-to-decoder loop
        for (int m = 0; m < 8; m++) begin
            exp_cw = enc(3'(m));
            for (int b = -1; b < 7; b++) begin
                mk = 7'b0000000;
                if (b >= 0) mk[b] = 1'b1;
                send(3'(m), mk, cw, acc1);
                chk("mask_apply", cw, exp_cw ^ mk);
                chk("decode", mld_decode(cw), exp_cw);
                consume();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
